fifo_reader: RTL
================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the FIFO byte/data width in bits.
REQ-002 The block SHALL have parameter WORD_BYTES, default 4, giving the number of FIFO entries packed per output word (range 2..8).
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port sel  input  1  block enable; gates FIFO-side acceptance and flush.
REQ-007 Port f_valid  input  1  FIFO read-side data available; driven by the FIFO's r_enable.
REQ-008 Port f_data  input  WIDTH  FIFO head entry; driven by the FIFO's r_data.
REQ-009 Port f_ready  output  1  reader accepts the head entry this cycle; drives the FIFO's r_ready.
REQ-010 Port flush  input  1  request to emit a partially filled word.
REQ-011 Port o_valid  output  1  packed word available.
REQ-012 Port o_data  output  WIDTH*WORD_BYTES  packed word; lane 0 = bits [WIDTH-1:0].
REQ-013 Port o_keep  output  WORD_BYTES  per-lane valid mask for o_data.
REQ-014 Port o_ready  input  1  downstream accepts the word this cycle.
REQ-015 Port words_out  output  16  count of words delivered; wraps 0xFFFF->0x0000.

Function
REQ-016 The block SHALL implement a two-state FSM, COLLECT and HOLD.
REQ-017 In COLLECT: f_ready = sel, and o_valid = 0.
REQ-018 In HOLD: f_ready = 0, and o_valid = 1.
REQ-019 Byte accept SHALL occur when f_valid && f_ready; f_data is written to lane idx, and idx increments, where idx is a lane index of width $clog2(WORD_BYTES) that starts at 0.
REQ-020 An accept at idx == WORD_BYTES-1 SHALL move to HOLD with o_keep = all ones; o_valid is asserted the next cycle (1-cycle latency).
REQ-021 flush in COLLECT with sel=1 and a lane count (idx plus any same-cycle accept) > 0 SHALL move to HOLD with o_keep = (1<<count)-1, the lowest count lanes set.
REQ-022 When flush coincides with an accept, the accepted byte SHALL be included in the flushed word.
REQ-023 flush with count == 0, or with sel=0, SHALL be ignored with no state change.
REQ-024 flush in HOLD SHALL be ignored.
REQ-025 Unfilled lanes of o_data SHALL be zero.
REQ-026 o_data and o_keep SHALL be stable throughout HOLD.
REQ-027 In HOLD, o_valid && o_ready SHALL return the FSM to COLLECT, clear idx and all lanes, and increment words_out.
REQ-028 HOLD and the output handshake SHALL proceed regardless of sel.
REQ-029 sel=0 in COLLECT SHALL freeze idx and lane contents.
REQ-030 o_valid SHALL NOT depend combinationally on o_ready.
REQ-031 f_ready SHALL NOT depend combinationally on f_valid.
REQ-032 Sustained throughput SHALL be one word per WORD_BYTES+1 cycles with f_valid and o_ready held high.

Reset
REQ-033 While rst_n = 0, regardless of clk: FSM = COLLECT, idx = 0, all lanes = 0, o_valid = 0, o_keep = 0, o_data = 0, words_out = 0, and f_ready = 0.
REQ-034 Reset asserted mid-HOLD SHALL discard the pending word with no handshake and no words_out increment.
REQ-035 After rst_n deasserts, f_ready SHALL follow sel from the first clock edge.

Verification
REQ-036 Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with sel=1 and o_ready=1 -> o_data = 0x44332211, o_keep = 0xF one cycle after the 4th accept; words_out = 1.
REQ-037 Same stimulus with o_ready=0 for 5 cycles -> o_valid held, o_data stable, f_ready=0, FIFO not drained; completes on o_ready=1.
REQ-038 0xAA, 0xBB, then flush -> o_data = 0x0000BBAA, o_keep = 0x3.
REQ-039 0x01, 0x02, then 0x03 with flush in the same cycle -> o_data = 0x00030201, o_keep = 0x7.
REQ-040 flush while empty, and flush with sel=0 after 1 byte -> no o_valid; next 3 bytes complete a full word.
REQ-041 Pulse rst_n low mid-HOLD -> outputs zero immediately; the next 4 bytes produce a correct word; words_out = 1 after the 0xFFFF wrap check is run separately (65536 words -> 0x0000).

Source files
------------

// File: rtl/fifo_reader.sv
// Packs WORD_BYTES consecutive FIFO entries into one output word with a per-lane keep mask.
// A flush emits a partially filled word; the word is held until the downstream accepts it.
module fifo_reader #(
  parameter int WIDTH      = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sel,
  input  logic                        f_valid,
  input  logic [WIDTH-1:0]            f_data,
  output logic                        f_ready,
  input  logic                        flush,
  output logic                        o_valid,
  output logic [WIDTH*WORD_BYTES-1:0] o_data,
  output logic [WORD_BYTES-1:0]       o_keep,
  input  logic                        o_ready,
  output logic [15:0]                 words_out
);

  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [WORD_BYTES-1:0][WIDTH-1:0]   lanes_q, lanes_d;
  logic [WORD_BYTES-1:0]              keep_q, keep_d;
  logic [15:0]                        words_q, words_d;
  logic                               accept;
  logic [CNT_W-1:0]                   count;

  // Lowest n lanes set; built bitwise so n == WORD_BYTES needs no wider shift.
  function automatic logic [WORD_BYTES-1:0] low_mask(input logic [CNT_W-1:0] n);
    logic [WORD_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < WORD_BYTES; i++) m[i] = (CNT_W'(i) < n);
    return m;
  endfunction

  assign f_ready   = rst_n && sel && (state_q == COLLECT);
  assign o_valid   = (state_q == HOLD);
  assign o_data    = lanes_q;
  assign o_keep    = keep_q;
  assign words_out = words_q;
  assign accept    = f_valid && f_ready;
  assign count     = {1'b0, idx_q} + CNT_W'(accept);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    keep_d  = keep_q;
    words_d = words_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          lanes_d[idx_q] = f_data;
          idx_d          = idx_q + IDX_W'(1);
        end
        // A same-cycle accept is already counted, so a flush includes that byte.
        if (accept && idx_q == LAST_IDX) begin
          state_d = HOLD;
          keep_d  = '1;
        end else if (flush && sel && count != '0) begin
          state_d = HOLD;
          keep_d  = low_mask(count);
        end
      end
      HOLD: begin
        if (o_ready) begin
          state_d = COLLECT;
          idx_d   = '0;
          lanes_d = '0;
          keep_d  = '0;
          words_d = words_q + 16'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      lanes_q <= '0;
      keep_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      keep_q  <= keep_d;
      words_q <= words_d;
    end
  end

endmodule
